// File: rtl/audio_pkg.sv
// Shared audio-path constants: default sample width, frame length and the
// two-state frame-collection FSM encoding.
package audio_pkg;

   localparam int DATA_W_DEF    = 16;
   localparam int FRAME_LEN_DEF = 64;

   typedef logic [0:0] state_t;
   localparam state_t IDLE    = 1'b0;
   localparam state_t COLLECT = 1'b1;

endpackage

// File: rtl/overlap_add_if.sv
// Frame-in / DAC-out signal bundle for overlap_add; the producer side drives
// the frame stream and sample tick, the consumer side returns sample and flags.
interface overlap_add_if #(
   parameter int DATA_W = 16
);
   logic                     sample_tick;
   logic                     frame_start;
   logic                     frame_valid;
   logic signed [DATA_W-1:0] frame_data;
   logic signed [DATA_W-1:0] dac_data;
   logic                     frame_done;
   logic                     late;
   logic                     overrun;

   modport master (
      output sample_tick, frame_start, frame_valid, frame_data,
      input  dac_data, frame_done, late, overrun
   );

   modport slave (
      input  sample_tick, frame_start, frame_valid, frame_data,
      output dac_data, frame_done, late, overrun
   );
endinterface

// File: rtl/ola_sat.sv
// Output stage: arithmetic right shift of an accumulator word, then clamp
// (OVERLAP_ADD_SAT_EN defined) or two's-complement truncate to DATA_W bits.
module ola_sat #(
   parameter int ACC_W  = 20,
   parameter int DATA_W = 16,
   parameter int SHIFT  = 2
) (
   input  logic signed [ACC_W-1:0]  acc_val,
   output logic signed [DATA_W-1:0] out_val
);

   logic signed [ACC_W-1:0] shifted;

   assign shifted = acc_val >>> SHIFT;

`ifdef OVERLAP_ADD_SAT_EN
   localparam logic signed [ACC_W-1:0] MAX_V =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_V =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   always_comb begin
      if (shifted > MAX_V)      out_val = MAX_V[DATA_W-1:0];
      else if (shifted < MIN_V) out_val = MIN_V[DATA_W-1:0];
      else                      out_val = shifted[DATA_W-1:0];
   end
`else
   logic unused_hi;

   assign out_val   = shifted[DATA_W-1:0];
   assign unused_hi = ^shifted[ACC_W-1:DATA_W];
`endif

endmodule

// File: rtl/overlap_add.sv
// Overlap-add frame reassembly: sliding accumulator with add-at-playback-
// position, one sample shifted out per sample_tick. Saturation: OVERLAP_ADD_SAT_EN.
module overlap_add
   import audio_pkg::*;
#(
   parameter int FRAME_LEN = FRAME_LEN_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ACC_W     = 20,
   parameter int SHIFT     = 2
) (
   input logic          mclk,
   input logic          rst,
   overlap_add_if.slave bus
);

   localparam int IDX_W = $clog2(FRAME_LEN);

   state_t                   state;
   logic [IDX_W-1:0]         wr_idx;
   logic [IDX_W:0]           drift;
   logic signed [ACC_W-1:0]  acc [FRAME_LEN];
   logic signed [DATA_W-1:0] dac_q;
   logic                     done_q, late_q, overrun_q;

   logic signed [IDX_W+1:0]  target;
   logic signed [ACC_W-1:0]  data_ext, out_unused;
   logic signed [DATA_W-1:0] out_val;
   logic [IDX_W-1:0]         src_idx, dst_idx;
   logic                     accept, wr_last, add_en, add_late;

   assign target   = $signed({2'b00, wr_idx}) - $signed({1'b0, drift});
   assign data_ext = {{(ACC_W-DATA_W){bus.frame_data[DATA_W-1]}}, bus.frame_data};
   assign accept   = (state == COLLECT) && bus.frame_valid && !bus.frame_start;
   assign wr_last  = accept && (wr_idx == IDX_W'(FRAME_LEN-1));

   // NOTE: every output of this block gets a default first, so no latch can form.
   always_comb begin
      add_en   = 1'b0;
      add_late = 1'b0;
      src_idx  = '0;
      dst_idx  = '0;
      if (accept) begin
         if (target[IDX_W+1] || (bus.sample_tick && target == '0)) begin
            add_late = 1'b1;
         end else begin
            add_en  = 1'b1;
            src_idx = target[IDX_W-1:0];
            dst_idx = bus.sample_tick ? src_idx - IDX_W'(1) : src_idx;
         end
      end
   end

   ola_sat #(.ACC_W(ACC_W), .DATA_W(DATA_W), .SHIFT(SHIFT)) u_sat (
      .acc_val (acc[0]),
      .out_val (out_val)
   );

   // NOTE: the accumulator is small and must read as silence after reset, so it is reset like any other register.
   always_ff @(posedge mclk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         wr_idx    <= '0;
         drift     <= '0;
         dac_q     <= '0;
         done_q    <= 1'b0;
         late_q    <= 1'b0;
         overrun_q <= 1'b0;
         for (int k = 0; k < FRAME_LEN; k++) acc[k] <= '0;
      end else begin
         done_q <= wr_last;
         if (add_late) late_q <= 1'b1;

         if (bus.frame_start) begin
            if (state == COLLECT) overrun_q <= 1'b1;
            state  <= COLLECT;
            wr_idx <= '0;
            drift  <= '0;
         end else begin
            if (accept)  wr_idx <= wr_idx + IDX_W'(1);
            if (wr_last) state  <= IDLE;
            if (state == COLLECT && bus.sample_tick && drift != (IDX_W+1)'(FRAME_LEN))
               drift <= drift + (IDX_W+1)'(1);
         end

         if (bus.sample_tick) begin
            dac_q <= out_val;
            for (int k = 0; k < FRAME_LEN-1; k++) acc[k] <= acc[k+1];
            acc[FRAME_LEN-1] <= '0;
         end
         // NOTE: non-blocking updates resolve last-wins, so the add overrides the shifted copy of its slot.
         if (add_en) acc[dst_idx] <= acc[src_idx] + data_ext;
      end
   end

   assign out_unused       = '0;
   assign bus.dac_data     = dac_q;
   assign bus.frame_done   = done_q;
   assign bus.late         = late_q;
   assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_overlap_add.sv
// Self-checking bench for overlap_add: a scoreboard queue of expected dac_data
// values is filled by each scenario and drained by a monitor on every sample_tick.
module tb_overlap_add;

   logic mclk = 1'b0;
   logic rst  = 1'b0;

   always #5 mclk = ~mclk;

   overlap_add_if #(.DATA_W(16)) bus ();

   overlap_add dut (
      .mclk (mclk),
      .rst  (rst),
      .bus  (bus)
   );

   int errors     = 0;
   int checks     = 0;
   int done_count = 0;
   logic signed [15:0] exp_q [$];
   logic signed [15:0] exp_v;

   // Scoreboard monitor: each accepted tick produces one dac_data update.
   always @(posedge mclk) begin
      if (bus.frame_done === 1'b1) done_count++;
      if (bus.sample_tick === 1'b1 && rst === 1'b1) begin
         #1;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL dac_data: tick with no expected value queued, got %0d", bus.dac_data);
         end else begin
            exp_v = exp_q.pop_front();
            if (bus.dac_data !== exp_v) begin
               errors++;
               $display("FAIL dac_data: got %0d expected %0d at %0t", bus.dac_data, exp_v, $time);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic cyc();
      @(posedge mclk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.sample_tick = 1'b0;
      bus.frame_start = 1'b0;
      bus.frame_valid = 1'b0;
      bus.frame_data  = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      cyc();
      cyc();
      rst = 1'b1;
      cyc();
      done_count = 0;
   endtask

   task automatic push_n(input int v, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(16'(v));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         bus.sample_tick = 1'b1;
         cyc();
         bus.sample_tick = 1'b0;
         cyc();
      end
   endtask

   task automatic send_frame(input logic signed [15:0] v);
      bus.frame_start = 1'b1;
      cyc();
      bus.frame_start = 1'b0;
      for (int i = 0; i < 64; i++) begin
         bus.frame_valid = 1'b1;
         bus.frame_data  = v;
         cyc();
      end
      bus.frame_valid = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      cyc();
      checks += 4;
      if (bus.dac_data !== 16'sd0) begin errors++; $display("FAIL reset_dac: got %0d expected 0", bus.dac_data); end
      if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.frame_done); end
      if (bus.late !== 1'b0)       begin errors++; $display("FAIL reset_late: got %b expected 0", bus.late); end
      if (bus.overrun !== 1'b0)    begin errors++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
      rst = 1'b1;
      cyc();
      push_n(0, 3);
      ticks(3);
      checks += 2;
      if (bus.late !== 1'b0 || bus.overrun !== 1'b0) begin
         errors++; $display("FAIL idle_flags: got late=%b overrun=%b expected 0 0", bus.late, bus.overrun);
      end
      if (exp_q.size() != 0) begin errors++; $display("FAIL idle_queue: %0d left expected 0", exp_q.size()); end
   endtask

   task automatic test_single_frame();
      do_reset();
      send_frame(16'sd400);
      checks += 3;
      if (bus.frame_done !== 1'b1) begin errors++; $display("FAIL done_pulse: got %b expected 1", bus.frame_done); end
      cyc();
      if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL done_width: got %b expected 0", bus.frame_done); end
      if (done_count != 1) begin errors++; $display("FAIL done_count: got %0d expected 1", done_count); end
      push_n(100, 64);
      push_n(0, 2);
      ticks(66);
      checks += 2;
      if (bus.late !== 1'b0 || bus.overrun !== 1'b0) begin
         errors++; $display("FAIL single_flags: got late=%b overrun=%b expected 0 0", bus.late, bus.overrun);
      end
      if (exp_q.size() != 0) begin errors++; $display("FAIL single_queue: %0d left expected 0", exp_q.size()); end
   endtask

   task automatic test_two_frames();
      do_reset();
      send_frame(16'sd400);
      push_n(100, 12);
      ticks(12);
      send_frame(16'sd400);
      cyc();
      push_n(200, 52);
      push_n(100, 12);
      push_n(0, 1);
      ticks(65);
      checks += 3;
      if (done_count != 2)       begin errors++; $display("FAIL two_done: got %0d expected 2", done_count); end
      if (bus.overrun !== 1'b0)  begin errors++; $display("FAIL two_overrun: got %b expected 0", bus.overrun); end
      if (exp_q.size() != 0)     begin errors++; $display("FAIL two_queue: %0d left expected 0", exp_q.size()); end
   endtask

   task automatic test_saturation();
      do_reset();
      repeat (4) send_frame(16'sh7FFF);
      cyc();
      push_n(32767, 2);
      ticks(2);
      do_reset();
      repeat (8) send_frame(16'sh7FFF);
      cyc();
`ifdef OVERLAP_ADD_SAT_EN
      push_n(32767, 2);
`else
      push_n(-2, 2);
`endif
      ticks(2);
      checks += 2;
      if (bus.overrun !== 1'b0) begin errors++; $display("FAIL sat_overrun: got %b expected 0", bus.overrun); end
      if (exp_q.size() != 0)    begin errors++; $display("FAIL sat_queue: %0d left expected 0", exp_q.size()); end
   endtask

   task automatic test_late();
      do_reset();
      bus.frame_start = 1'b1;
      cyc();
      bus.frame_start = 1'b0;
      bus.frame_valid = 1'b1;
      bus.frame_data  = 16'sd1000;
      bus.sample_tick = 1'b1;
      push_n(0, 1);
      cyc();
      bus.sample_tick = 1'b0;
      checks++;
      if (bus.late !== 1'b1) begin errors++; $display("FAIL late_set: got %b expected 1", bus.late); end
      for (int i = 1; i < 64; i++) begin
         bus.frame_data = 16'(40 * i);
         cyc();
      end
      bus.frame_valid = 1'b0;
      checks++;
      if (bus.frame_done !== 1'b1) begin errors++; $display("FAIL late_done: got %b expected 1", bus.frame_done); end
      cyc();
      for (int i = 1; i < 64; i++) push_n(10 * i, 1);
      push_n(0, 1);
      ticks(64);
      checks += 2;
      if (bus.late !== 1'b1)  begin errors++; $display("FAIL late_sticky: got %b expected 1", bus.late); end
      if (exp_q.size() != 0)  begin errors++; $display("FAIL late_queue: %0d left expected 0", exp_q.size()); end
   endtask

   task automatic test_overrun();
      do_reset();
      bus.frame_start = 1'b1;
      cyc();
      bus.frame_start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus.frame_valid = 1'b1;
         bus.frame_data  = 16'sd400;
         cyc();
      end
      bus.frame_start = 1'b1;
      bus.frame_data  = 16'sd4000;
      cyc();
      bus.frame_start = 1'b0;
      bus.frame_data  = 16'sd400;
      checks += 2;
      if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", bus.overrun); end
      if (done_count != 0)      begin errors++; $display("FAIL overrun_early_done: got %0d expected 0", done_count); end
      for (int i = 0; i < 63; i++) cyc();
      checks++;
      if (bus.frame_done !== 1'b0 || done_count != 0) begin
         errors++; $display("FAIL overrun_63: got done=%b count=%0d expected 0 0", bus.frame_done, done_count);
      end
      cyc();
      bus.frame_valid = 1'b0;
      checks++;
      if (bus.frame_done !== 1'b1) begin errors++; $display("FAIL overrun_done: got %b expected 1", bus.frame_done); end
      cyc();
      push_n(200, 10);
      push_n(100, 54);
      push_n(0, 1);
      ticks(65);
      checks += 3;
      if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", bus.overrun); end
      if (bus.late !== 1'b0)    begin errors++; $display("FAIL overrun_late: got %b expected 0", bus.late); end
      if (exp_q.size() != 0)    begin errors++; $display("FAIL overrun_queue: %0d left expected 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      bus.frame_start = 1'b1;
      cyc();
      bus.frame_start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         bus.frame_valid = 1'b1;
         bus.frame_data  = 16'sd400;
         cyc();
      end
      bus.frame_valid = 1'b0;
      push_n(100, 1);
      ticks(1);
      bus.frame_start = 1'b1;
      cyc();
      bus.frame_start = 1'b0;
      rst = 1'b0;
      #2;
      checks += 2;
      if (bus.dac_data !== 16'sd0) begin errors++; $display("FAIL midrst_dac: got %0d expected 0", bus.dac_data); end
      if (bus.overrun !== 1'b0)    begin errors++; $display("FAIL midrst_overrun: got %b expected 0", bus.overrun); end
      cyc();
      rst = 1'b1;
      cyc();
      done_count = 0;
      for (int i = 0; i < 5; i++) begin
         bus.frame_valid = 1'b1;
         bus.frame_data  = 16'sd800;
         cyc();
      end
      bus.frame_valid = 1'b0;
      push_n(0, 3);
      ticks(3);
      checks += 3;
      if (bus.late !== 1'b0) begin errors++; $display("FAIL midrst_late: got %b expected 0", bus.late); end
      if (done_count != 0)   begin errors++; $display("FAIL midrst_done: got %0d expected 0", done_count); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_queue: %0d left expected 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_two_frames();
      test_saturation();
      test_late();
      test_overrun();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/overlap_add.md
# overlap_add

Reassembles processed audio frames into a continuous sample stream for the DAC path. Accepts one frame of FRAME_LEN time-domain samples (the output of the inverse-transform stage, delivered one sample per valid strobe), adds it into a sliding accumulator at the current playback position, and shifts one finished sample out per audio sample tick. Sits between the frame-processing pipeline and `i2s_write`, on the `mclk` domain, mirroring the capture/frame-out path on the ADC side.

## Interface
- FRAME_LEN, 64: samples per frame, power of two.
- DATA_W, 16: input and output sample width, signed.
- ACC_W, 20: accumulator word width, signed, at least DATA_W+2.
- SHIFT, 2: arithmetic right shift applied to the accumulator before output (overlap gain compensation).

Ports:
- mclk  in  1  sole clock, 12.288 MHz.
- rst  in  1  reset; asynchronous, active-low.
- sample_tick  in  1  one-cycle pulse per output sample (8 kHz rate).
- frame_start  in  1  one-cycle pulse; the next frame begins.
- frame_valid  in  1  frame_data carries a frame sample this cycle.
- frame_data  in  DATA_W  signed frame sample, in index order 0..FRAME_LEN-1.
- dac_data  out  DATA_W  current output sample, held between ticks; feeds `i2s_write`.
- frame_done  out  1  one-cycle pulse after the last sample of a frame is accepted.
- late  out  1  sticky: a frame sample arrived after its slot had already played.
- overrun  out  1  sticky: frame_start arrived while a frame was incomplete.

## Operation
- State machine states: IDLE and COLLECT. Reset → IDLE.
- Storage: acc[0..FRAME_LEN-1], ACC_W each; acc[0] is the next sample to play.
- IDLE: frame_valid ignored. frame_start → COLLECT, wr_idx=0, drift=0.
- COLLECT: on frame_valid, target = wr_idx − drift; if target ≥ 0, acc[target] += sign-extended frame_data (wraps modulo 2^ACC_W); else drop sample, set late. wr_idx increments on every frame_valid.
- wr_idx reaching FRAME_LEN−1 with frame_valid → that sample is processed normally, frame_done pulses next cycle, state → IDLE.
- sample_tick (any state): dac_data ← out(acc[0]); acc[k] ← acc[k+1] for k < FRAME_LEN−1; acc[FRAME_LEN−1] ← 0. In COLLECT, drift increments, saturating at FRAME_LEN.
- sample_tick and frame_valid in same cycle: add applies to the post-shift position, i.e. acc[target−1] (new) = acc[target] (old) + data; target 0 in that cycle is treated as late (dropped, late set).
- frame_start while in COLLECT: partial contributions kept, wr_idx and drift cleared, frame restarts, overrun set. frame_start coinciding with frame_valid: restart wins; that sample is dropped.
- out(x) = x >>> SHIFT, then reduced to DATA_W per Configuration.
- late and overrun clear only on reset.

## Timing
- Reset values: dac_data 0, frame_done 0, late 0, overrun 0, all acc 0, state IDLE, wr_idx 0, drift 0.
- dac_data updates on the mclk edge after sample_tick is sampled (1-cycle latency); stable for the whole tick interval.
- A sample added at acc[k] appears on dac_data after k+1 sample_ticks.
- frame_done: exactly one cycle, registered, the cycle after the final accepted frame_valid.
- Reset asserted mid-frame: everything returns to reset values immediately; no partial output.
- Throughput: one frame_valid per cycle sustained.

## Configuration
- OVERLAP_ADD_SAT_EN defined: shifted value clamped to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Not defined: shifted value truncated to its low DATA_W bits (two's-complement wrap).

## Structure
- Shared package `audio_pkg`: DATA_W default, state encoding (IDLE, COLLECT), default FRAME_LEN.
- One sub-module: `ola_sat` — combinational shift plus saturate/truncate (macro-controlled), used on the output path.
- Shift-register accumulator and FSM live in `overlap_add`.

## Test plan
- Reset, then 3 sample_ticks with no frames → dac_data 0, flags 0.
- Frame of 64 samples all 16'd400, no ticks during delivery; SHIFT=2 → next 64 ticks output 100, then 0; frame_done pulses once.
- Two identical frames of 16'd400, second started after 12 ticks → outputs 100 for 12 ticks, then 200 for 52, then 100 for 12.
- Frame of 16'h7FFF ×4 overlapping (4 frames, no ticks) → with OVERLAP_ADD_SAT_EN output 32767 (acc 131068 >>2 = 32767); without, low 16 bits of 32767 → 32767; with 8 frames, sat gives 32767, wrap gives 16'hFFFE… (−2).
- sample_tick asserted the same cycle as frame_valid at wr_idx 0, drift 0 → late set, sample dropped, subsequent samples land one slot lower.
- frame_start after 10 valid samples → overrun set, wr_idx restarts, frame_done only after 64 further valids.
